// File: rtl/sram_model_pkg.sv
// Shared types, constants and lane-merge helper for the 1RW+1R SRAM model.
package sram_model_pkg;

  // Collision policy selectors for the port-1 read of a word being written.
  localparam int unsigned COLL_OLD = 0;
  localparam int unsigned COLL_NEW = 1;

  // Widest word the merge helper handles; callers widen/truncate with casts.
  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned IDX_W  = 10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  // Per-lane select: lanes whose mask bit is set take new_word, others keep old_word.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_DW-1:0] mask,
    input int unsigned       lane_w
  );
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < MAX_DW; b++) begin
      if (mask[IDX_W'(b / lane_w)]) res[IDX_W'(b)] = new_word[IDX_W'(b)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_1rw1r_wmask_model_if.sv
// Request/response bundle of the 1RW+1R SRAM model.
interface sram_1rw1r_wmask_model_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned WMASK_WIDTH = 4
);
  logic                   ready;
  logic                   csb0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic [DATA_WIDTH-1:0]  dout0;
  logic                   dout0_valid;
  logic                   csb1;
  logic [ADDR_WIDTH-1:0]  addr1;
  logic [DATA_WIDTH-1:0]  dout1;
  logic                   dout1_valid;
  logic                   collision;

  modport master (
    input  ready, dout0, dout0_valid, dout1, dout1_valid, collision,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
    output ready, dout0, dout0_valid, dout1, dout1_valid, collision,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// Optional extra output stage for one read port (data held between reads).
module sram_rd_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter bit          STAGE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             flag_o
);

  if (STAGE) begin : g_stage
    // One-cycle delay of the read result; data only moves when a read completes.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        valid_o <= 1'b0;
        flag_o  <= 1'b0;
        data_o  <= '0;
      end else begin
        valid_o <= valid_i;
        flag_o  <= flag_i & valid_i;
        if (valid_i) data_o <= data_i;
      end
    end
  end else begin : g_bypass
    // Clock and reset have no load when the stage is bypassed.
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST_N;
    assign valid_o = valid_i;
    assign data_o  = data_i;
    assign flag_o  = flag_i;
  end

endmodule

// File: rtl/sram_1rw1r_wmask_model.sv
// 1RW+1R SRAM model: masked writes, 1/2-cycle reads, collision policy, zero sweep.
module sram_1rw1r_wmask_model
  import sram_model_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned WMASK_WIDTH    = 4,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned COLLISION_MODE = COLL_OLD,
  parameter int unsigned INIT_ON_RESET  = 1
) (
  input logic                     CLK,
  input logic                     RST_N,
  sram_1rw1r_wmask_model_if.slave bus
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW        = DATA_WIDTH / WMASK_WIDTH;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "sram_1rw1r_wmask_model: RD_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_WIDTH) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
    $fatal(1, "sram_1rw1r_wmask_model: bad DATA_WIDTH/WMASK_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  fsm_t                  state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ready_q;

  logic                  wr0_c, rd0_c, rd1_c, coll_c;
  logic [DATA_WIDTH-1:0] merged_c, word1_c;

  logic                  rd0_q, rd1_q, coll_q;
  logic [DATA_WIDTH-1:0] d0_q, d1_q;
  logic                  coll0_unused;

  // Request decode; nothing is accepted until the array is ready.
  always_comb begin
    wr0_c    = ready_q & ~bus.csb0 & ~bus.web0;
    rd0_c    = ready_q & ~bus.csb0 &  bus.web0;
    rd1_c    = ready_q & ~bus.csb1;
    coll_c   = wr0_c & rd1_c & (bus.addr0 == bus.addr1);
    merged_c = DATA_WIDTH'(lane_merge(MAX_DW'(mem[bus.addr0]), MAX_DW'(bus.din0),
                                      MAX_DW'(bus.wmask0), LW));
    word1_c  = mem[bus.addr1];
    if (coll_c && COLLISION_MODE == COLL_NEW) word1_c = merged_c;
  end

  // Sweep / ready control: INIT zeroes one word per edge, then RUN forever.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:  ready_q <= 1'b1;
        default: state   <= ST_INIT;
      endcase
    end
  end

  // Storage array: sweep write during INIT, masked port-0 write in RUN.
  always_ff @(posedge CLK) begin
    if (state == ST_INIT) mem[cnt] <= '0;
    else if (wr0_c)       mem[bus.addr0] <= merged_c;
  end

  // First read stage: capture read words (held between reads) and valid/collision pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd0_q  <= 1'b0;
      rd1_q  <= 1'b0;
      coll_q <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
    end else begin
      rd0_q  <= rd0_c;
      rd1_q  <= rd1_c;
      coll_q <= coll_c;
      if (rd0_c) d0_q <= mem[bus.addr0];
      if (rd1_c) d1_q <= word1_c;
    end
  end

  assign bus.ready = ready_q;

  sram_rd_pipe #(.WIDTH(DATA_WIDTH), .STAGE(RD_LATENCY == 2)) u_pipe0 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .valid_i (rd0_q),
    .data_i  (d0_q),
    .flag_i  (1'b0),
    .valid_o (bus.dout0_valid),
    .data_o  (bus.dout0),
    .flag_o  (coll0_unused)
  );

  sram_rd_pipe #(.WIDTH(DATA_WIDTH), .STAGE(RD_LATENCY == 2)) u_pipe1 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .valid_i (rd1_q),
    .data_i  (d1_q),
    .flag_i  (coll_q),
    .valid_o (bus.dout1_valid),
    .data_o  (bus.dout1),
    .flag_o  (bus.collision)
  );

endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// Scoreboard bench: two instances (lat1/old-data, lat2/new-data) on identical stimulus.
module tb_sram_1rw1r_wmask_model;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 128;

  typedef struct {
    int unsigned due;
    logic [DW-1:0] data;
    logic coll;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic mon_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned since_rst = 0;

  logic [DW-1:0] m [DEPTH];
  logic [DW-1:0] last_d [4];
  exp_t sbq [4][$];

  always #5 CLK = ~CLK;

  sram_1rw1r_wmask_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus_a ();
  sram_1rw1r_wmask_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus_b ();

  sram_1rw1r_wmask_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
    .RD_LATENCY(1), .COLLISION_MODE(0), .INIT_ON_RESET(1)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_a));

  sram_1rw1r_wmask_model #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
    .RD_LATENCY(2), .COLLISION_MODE(1), .INIT_ON_RESET(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_b));

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) since_rst <= 0;
    else if (since_rst < 100000) since_rst <= since_rst + 1;
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [MW-1:0] mk);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < MW; i++) if (mk[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare one port against the head of its expectation queue.
  task automatic check_port(input int k, input logic v, input logic [DW-1:0] d, input logic c);
    exp_t e;
    checks++;
    if (v) begin
      if (sbq[k].size() == 0) begin
        errors++;
        $display("FAIL spurious_valid port%0d cyc=%0d got valid=1 data=%h expected no read", k, cyc, d);
      end else begin
        e = sbq[k].pop_front();
        last_d[k] = e.data;
        if (e.due != cyc || d !== e.data || c !== e.coll) begin
          errors++;
          $display("FAIL read port%0d cyc=%0d got data=%h coll=%b expected data=%h coll=%b at cyc=%0d",
                   k, cyc, d, c, e.data, e.coll, e.due);
        end
      end
    end else begin
      if (d !== last_d[k] || c !== 1'b0) begin
        errors++;
        $display("FAIL hold port%0d cyc=%0d got data=%h coll=%b expected data=%h coll=0",
                 k, cyc, d, c, last_d[k]);
      end
      if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
        e = sbq[k].pop_front();
        errors++;
        $display("FAIL missing_valid port%0d cyc=%0d got valid=0 expected data=%h", k, cyc, e.data);
      end
    end
  endtask

  // Monitor: ready and every read port checked once per cycle, mid-cycle.
  always @(negedge CLK) begin
    if (RST_N && mon_en) begin
      chk("ready_a", DW'(bus_a.ready), DW'(since_rst >= DEPTH));
      chk("ready_b", DW'(bus_b.ready), DW'(since_rst >= DEPTH));
      check_port(0, bus_a.dout0_valid, bus_a.dout0, 1'b0);
      check_port(1, bus_a.dout1_valid, bus_a.dout1, bus_a.collision);
      check_port(2, bus_b.dout0_valid, bus_b.dout0, 1'b0);
      check_port(3, bus_b.dout1_valid, bus_b.dout1, bus_b.collision);
    end
  end

  // Apply one request to both instances and record what the model expects from it.
  task automatic step(input logic c0, input logic w0, input logic [MW-1:0] mk,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic c1, input logic [AW-1:0] a1);
    int unsigned edge_n;
    logic        acc, wr, coll;
    logic [DW-1:0] newv;
    bus_a.csb0 = c0; bus_a.web0 = w0; bus_a.wmask0 = mk; bus_a.addr0 = a0; bus_a.din0 = d0;
    bus_a.csb1 = c1; bus_a.addr1 = a1;
    bus_b.csb0 = c0; bus_b.web0 = w0; bus_b.wmask0 = mk; bus_b.addr0 = a0; bus_b.din0 = d0;
    bus_b.csb1 = c1; bus_b.addr1 = a1;
    edge_n = cyc + 1;
    acc = (since_rst >= DEPTH) && RST_N;
    if (acc) begin
      wr   = !c0 && !w0;
      coll = wr && !c1 && (a0 == a1);
      newv = merge(m[a0], d0, mk);
      if (!c0 && w0) begin
        sbq[0].push_back('{edge_n, m[a0], 1'b0});
        sbq[2].push_back('{edge_n + 1, m[a0], 1'b0});
      end
      if (!c1) begin
        sbq[1].push_back('{edge_n, m[a1], coll});
        sbq[3].push_back('{edge_n + 1, coll ? newv : m[a1], coll});
      end
      if (wr) m[a0] = newv;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'h0, 7'h0, 32'h0, 1'b1, 7'h0);
  endtask

  task automatic rand_step();
    logic [AW-1:0] a0, a1;
    a0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    a1 = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom_range(0, 7));
    step($urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom), a0, $urandom,
         $urandom_range(0, 2) == 0, a1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, DW'(bus_a.ready) | DW'(bus_b.ready), 32'h0);
    chk({tag, "_dout_a"}, bus_a.dout0 | bus_a.dout1, 32'h0);
    chk({tag, "_dout_b"}, bus_b.dout0 | bus_b.dout1, 32'h0);
    chk({tag, "_flags"}, DW'({bus_a.dout0_valid, bus_a.dout1_valid, bus_a.collision,
                              bus_b.dout0_valid, bus_b.dout1_valid, bus_b.collision}), 32'h0);
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 4; k++) begin
      sbq[k].delete();
      last_d[k] = '0;
    end
  endtask

  initial begin
    bus_a.csb0 = 1'b1; bus_a.web0 = 1'b1; bus_a.wmask0 = '0; bus_a.addr0 = '0; bus_a.din0 = '0;
    bus_a.csb1 = 1'b1; bus_a.addr1 = '0;
    bus_b.csb0 = 1'b1; bus_b.web0 = 1'b1; bus_b.wmask0 = '0; bus_b.addr0 = '0; bus_b.din0 = '0;
    bus_b.csb1 = 1'b1; bus_b.addr1 = '0;
    clear_sb();
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("reset0");
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    mon_en = 1'b1;

    // Partial sweep with junk requests, then reset at sweep count 60.
    repeat (60) rand_step();
    #2 RST_N = 1'b0;
    clear_sb();
    #1 check_reset_outputs("reset60");
    @(posedge CLK);
    #3 RST_N = 1'b1;
    for (int k = 0; k < DEPTH; k++) m[k] = '0;

    // Full sweep; late writes to already-swept words must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= 120) step(1'b0, 1'b0, 4'hF, AW'(i - 120), 32'hFFFF_FFFF, 1'b0, AW'(i - 120));
      else rand_step();
    end

    // First accepted request: port-1 read of the top word.
    step(1'b1, 1'b1, 4'h0, 7'h0, 32'h0, 1'b0, 7'h7F);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, AW'(i), 32'h0, 1'b0, AW'(7 - i));

    // Masked write over a known word.
    step(1'b0, 1'b0, 4'hF, 7'd5, 32'h1122_3344, 1'b1, 7'h0);
    step(1'b0, 1'b0, 4'b0101, 7'd5, 32'hDEAD_BEEF, 1'b1, 7'h0);
    step(1'b0, 1'b1, 4'h0, 7'd5, 32'h0, 1'b0, 7'd5);
    idle();
    idle();

    // Same-edge write + port-1 read, then back-to-back read of the new data.
    step(1'b0, 1'b0, 4'hF, 7'd9, 32'hAAAA_AAAA, 1'b0, 7'd9);
    step(1'b0, 1'b1, 4'h0, 7'd9, 32'h0, 1'b0, 7'd9);
    step(1'b0, 1'b0, 4'b0011, 7'd9, 32'h5555_5555, 1'b0, 7'd9);
    step(1'b0, 1'b0, 4'h0, 7'd9, 32'h1234_5678, 1'b0, 7'd9);
    repeat (4) idle();

    repeat (1500) rand_step();
    repeat (4) idle();

    for (int k = 0; k < 4; k++) chk($sformatf("drain_port%0d", k), DW'(sbq[k].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
